mips_bus_arbiter: RTL

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

---
 rtl/mips_bus_arbiter_pkg.sv | 12 +
 rtl/arb_watchdog.sv | 27 ++
 rtl/mips_bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types for the MIPS instruction/data bus arbiter.
package mips_bus_arbiter_pkg;

  localparam int unsigned WATCHDOG_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GRANT0 = 2'b01,
    ARB_GRANT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-cycle counter for one granted transfer; expired while count equals limit.
module arb_watchdog
  import mips_bus_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [WATCHDOG_W-1:0] limit,
  output logic                  expired
);

  logic [WATCHDOG_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WATCHDOG_W'(1);
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-requester Avalon arbiter (m0 = fetch, m1 = data) with a wait watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to m1.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam logic [WATCHDOG_W-1:0] WAIT_LIMIT = WATCHDOG_W'(MAX_WAIT);

  arb_state_t state;
  logic req0, req1, pick1;
  logic granted, sel1, own_read, own_write, own_req;
  logic expired, done, abort;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign granted   = (state != ARB_IDLE);
  assign sel1      = (state == ARB_GRANT1);
  assign own_read  = sel1 ? m1_read  : m0_read;
  assign own_write = sel1 ? m1_write : m0_write;
  assign own_req   = granted & (own_read | own_write);
  assign abort     = own_req & expired;
  assign done      = own_req & ~expired & ~waitrequest;
  assign bus_error = abort;

  arb_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~granted),
    .enable  (own_req & waitrequest & ~expired),
    .limit   (WAIT_LIMIT),
    .expired (expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // last1 remembers the previous owner; a tie goes to the other requester.
  logic last1;
  assign pick1 = req1 & (~req0 | ~last1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last1 <= 1'b1;
    end else if (state == ARB_IDLE && (req0 || req1)) begin
      last1 <= pick1;
    end
  end
`else
  assign pick1 = req1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      grant <= 2'b00;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick1) begin
            state <= ARB_GRANT1;
            grant <= 2'b10;
          end else if (req0) begin
            state <= ARB_GRANT0;
            grant <= 2'b01;
          end
        end
        default: begin
          // Owner is never pre-empted; leave only on completion, abort or drop.
          if (!own_req || done || abort) begin
            state <= ARB_IDLE;
            grant <= 2'b00;
          end
        end
      endcase
    end
  end

  always_comb begin
    address        = '0;
    writedata      = '0;
    byteenable     = '0;
    read           = 1'b0;
    write          = 1'b0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (granted) begin
      address    = sel1 ? m1_address    : m0_address;
      writedata  = sel1 ? m1_writedata  : m0_writedata;
      byteenable = sel1 ? m1_byteenable : m0_byteenable;
      write      = own_write & ~expired;
      read       = own_read & ~own_write & ~expired;
    end
    if (done || abort) begin
      if (sel1) begin
        m1_waitrequest = 1'b0;
        m1_readdata    = done ? readdata : '0;
      end else begin
        m0_waitrequest = 1'b0;
        m0_readdata    = done ? readdata : '0;
      end
    end
  end

endmodule
